// File: rtl/add_seq_arbiter.sv
// Two-requester arbiter feeding a byte-serial add/sub unit (one 8-bit slice per cycle).
// Define ADD_SEQ_ARB_RR_EN for round-robin grant; otherwise req0 has fixed priority.

module add8 #(
   parameter int n = 8
) (
   input  logic [n-1:0] a,
   input  logic [n-1:0] b,
   input  logic         cin,
   output logic [n-1:0] s,
   output logic         cout
);
   assign {cout, s} = {1'b0, a} + {1'b0, b} + {{n{1'b0}}, cin};
endmodule

module add_seq_arbiter #(
   parameter int WORDS = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req0_valid,
   output logic                 req0_ready,
   input  logic [8*WORDS-1:0]   req0_a,
   input  logic [8*WORDS-1:0]   req0_b,
   input  logic                 req0_sub,
   input  logic                 req1_valid,
   output logic                 req1_ready,
   input  logic [8*WORDS-1:0]   req1_a,
   input  logic [8*WORDS-1:0]   req1_b,
   input  logic                 req1_sub,
   output logic                 resp_valid,
   input  logic                 resp_ready,
   output logic                 resp_id,
   output logic [8*WORDS-1:0]   resp_sum,
   output logic                 resp_cout,
   output logic                 resp_ovf
);
   localparam int W  = 8*WORDS;
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [IW-1:0] LAST = IW'(WORDS-1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t        state, state_nx;
   logic [W-1:0]  op_a, op_b;
   logic [IW-1:0] idx;
   logic          carry;
   logic [7:0]    s;
   logic          co;
   logic          gnt0, gnt1, acc;
   logic [W-1:0]  sel_a, sel_b;
   logic          sel_sub;

   // operands shift down one byte per slice, so the adder always sees bits [7:0]
   add8 #(.n(8)) u_add (
      .a    (op_a[7:0]),
      .b    (op_b[7:0]),
      .cin  (carry),
      .s    (s),
      .cout (co)
   );

`ifdef ADD_SEQ_ARB_RR_EN
   logic last;

   always_ff @(posedge clk) begin
      if (rst)
         last <= 1'b1;
      else if (acc)
         last <= gnt1;
   end

   assign gnt0 = req0_valid & (~req1_valid | last);
`else
   assign gnt0 = req0_valid;
`endif
   assign gnt1 = req1_valid & ~gnt0;

   assign req0_ready = ~rst & (state == IDLE) & gnt0;
   assign req1_ready = ~rst & (state == IDLE) & gnt1;
   assign acc        = req0_ready | req1_ready;
   assign resp_valid = (state == DONE);

   assign sel_a   = gnt0 ? req0_a   : req1_a;
   assign sel_b   = gnt0 ? req0_b   : req1_b;
   assign sel_sub = gnt0 ? req0_sub : req1_sub;

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (acc) state_nx = RUN;
         RUN:     if (idx == LAST) state_nx = DONE;
         DONE:    if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         op_a      <= '0;
         op_b      <= '0;
         idx       <= '0;
         carry     <= 1'b0;
         resp_sum  <= '0;
         resp_cout <= 1'b0;
         resp_ovf  <= 1'b0;
         resp_id   <= 1'b0;
      end else begin
         state <= state_nx;
         unique case (state)
            IDLE: begin
               if (acc) begin
                  op_a    <= sel_a;
                  op_b    <= sel_sub ? ~sel_b : sel_b;
                  carry   <= sel_sub;
                  idx     <= '0;
                  resp_id <= gnt1;
               end
            end
            RUN: begin
               op_a  <= op_a >> 8;
               op_b  <= op_b >> 8;
               carry <= co;
               idx   <= idx + 1'b1;
               resp_sum[{idx, 3'b000} +: 8] <= s;
               if (idx == LAST) begin
                  resp_cout <= co;
                  resp_ovf  <= (op_a[7] == op_b[7]) && (s[7] != op_a[7]);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_add_seq_arbiter.sv
// Bench for add_seq_arbiter (WORDS=4): vector table, directed corner sequences
// and random traffic checked cycle by cycle against an arithmetic reference model.
`timescale 1ns/1ps
module tb_add_seq_arbiter;
   localparam int WORDS = 4;
   localparam int W     = 8*WORDS;
   localparam int LAT   = WORDS + 1;
`ifdef ADD_SEQ_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 0, req1_valid = 0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic         req0_sub = 0, req1_sub = 0;
   logic         resp_valid, resp_id, resp_cout, resp_ovf;
   logic         resp_ready = 0;
   logic [W-1:0] resp_sum;

   always #5 clk = ~clk;

   add_seq_arbiter #(.WORDS(WORDS)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_sub(req0_sub),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_sub(req1_sub),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_id(resp_id), .resp_sum(resp_sum),
      .resp_cout(resp_cout), .resp_ovf(resp_ovf)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // reference arithmetic from integer semantics
   function automatic void ref_op(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] sum, output bit cout, output bit ovf);
      longint ua, ub, sa, sb, r;
      ua = longint'({32'd0, a});
      ub = longint'({32'd0, b});
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
      if (sub) begin
         sum  = a - b;
         cout = (ua >= ub);
         r    = sa - sb;
      end else begin
         sum  = a + b;
         cout = ((ua + ub) >= 64'sd4294967296);
         r    = sa + sb;
      end
      ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648);
   endfunction

   bit           mon_on = 0;
   bit           m_busy = 0;
   int           m_cnt  = 0;
   bit           m_last = 1;
   logic [W-1:0] m_sum  = '0;
   bit           m_cout = 0, m_ovf = 0, m_id = 0;

   always @(negedge clk) begin : mon
      bit w0, w1, e0, e1, done;
      if (mon_on) begin
         if (m_busy) m_cnt++;
         done = m_busy && (m_cnt >= LAT);
         // lone request wins; on a tie req0 wins unless RR and req0 was served last
         w0 = req0_valid && !(req1_valid && RR && !m_last);
         w1 = req1_valid && !w0;
         e0 = !rst && !m_busy && w0;
         e1 = !rst && !m_busy && w1;
         chk("m_ready0", 64'(req0_ready), 64'(e0));
         chk("m_ready1", 64'(req1_ready), 64'(e1));
         chk("m_valid", 64'(resp_valid), 64'(done));
         if (!m_busy || done) begin
            chk("m_sum", 64'(resp_sum), 64'(m_sum));
            chk("m_cout", 64'(resp_cout), 64'(m_cout));
            chk("m_ovf", 64'(resp_ovf), 64'(m_ovf));
            chk("m_id", 64'(resp_id), 64'(m_id));
         end
         if (rst) begin
            m_busy = 0; m_cnt = 0; m_last = 1;
            m_sum = '0; m_cout = 0; m_ovf = 0; m_id = 0;
         end else if (done && resp_ready) begin
            m_busy = 0;
         end else if (e0 || e1) begin
            if (e0) ref_op(req0_sub, req0_a, req0_b, m_sum, m_cout, m_ovf);
            else    ref_op(req1_sub, req1_a, req1_b, m_sum, m_cout, m_ovf);
            m_id = e1; m_last = e1; m_busy = 1; m_cnt = 0;
         end
      end
   end

   typedef struct {
      bit           id;
      bit           sub;
      logic [W-1:0] a, b, sum;
      bit           cout, ovf;
   } vec_t;

   vec_t tbl[9];

   task automatic drive_req(input bit id, input bit v, input bit sub,
                            input logic [W-1:0] a, input logic [W-1:0] b);
      if (id) begin
         req1_valid = v; req1_sub = sub; req1_a = a; req1_b = b;
      end else begin
         req0_valid = v; req0_sub = sub; req0_a = a; req0_b = b;
      end
   endtask

   task automatic wait_accept(input bit id, input string name);
      bit got = 0;
      int n = 0;
      while (!got && n < 30) begin
         @(negedge clk);
         got = id ? req1_ready : req0_ready;
         n++;
      end
      chk(name, 64'(got), 64'd1);
   endtask

   task automatic run_op(input bit id, input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] sum, output bit cout, output bit ovf,
                         output bit rid, output int lat);
      bit got = 0;
      @(posedge clk); #1;
      drive_req(id, 1'b1, sub, a, b);
      wait_accept(id, "t_accept");
      @(posedge clk); #1;
      // operands change after acceptance; the unit must ignore them
      drive_req(id, 1'b0, ~sub, $urandom, $urandom);
      lat = 0;
      while (!got && lat < 30) begin
         @(negedge clk);
         lat++;
         got = resp_valid;
      end
      sum = resp_sum; cout = resp_cout; ovf = resp_ovf; rid = resp_id;
      @(posedge clk); #1 resp_ready = 1;
      @(posedge clk); #1 resp_ready = 0;
   endtask

   task automatic drain();
      @(posedge clk); #1;
      req0_valid = 0; req1_valid = 0; resp_ready = 1;
      repeat (LAT + 3) @(posedge clk);
      #1 resp_ready = 0;
   endtask

   function automatic logic [W-1:0] rnd_op();
      unique case ($urandom_range(0, 4))
         0: return '0;
         1: return '1;
         2: return 32'h7FFF_FFFF;
         3: return 32'h8000_0000;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      logic [W-1:0] sum;
      bit cout, ovf, rid;
      int lat, n, k;
      bit ids[4];
      logic [W-1:0] held;

      tbl[0] = '{0, 0, 32'd1,          32'd200,        32'd201,        0, 0};
      tbl[1] = '{1, 0, 32'hFFFF_FFFF,  32'd1,          32'd0,          1, 0};
      tbl[2] = '{0, 1, 32'd5,          32'd7,          32'hFFFF_FFFE,  0, 0};
      tbl[3] = '{1, 0, 32'h7FFF_FFFF,  32'd1,          32'h8000_0000,  0, 1};
      tbl[4] = '{0, 1, 32'd7,          32'd5,          32'd2,          1, 0};
      tbl[5] = '{1, 1, 32'h8000_0000,  32'd1,          32'h7FFF_FFFF,  1, 1};
      tbl[6] = '{0, 0, 32'h8000_0000,  32'h8000_0000,  32'd0,          1, 1};
      tbl[7] = '{1, 1, 32'd0,          32'd0,          32'd0,          1, 0};
      tbl[8] = '{0, 0, 32'h1234_5678,  32'h0FED_CBA9,  32'h2222_2221,  0, 0};

      repeat (2) @(posedge clk);
      #1 rst = 0;
      mon_on = 1;
      @(negedge clk);
      chk("reset_valid", 64'(resp_valid), 64'd0);
      chk("reset_sum", 64'(resp_sum), 64'd0);
      chk("reset_flags", 64'({resp_cout, resp_ovf, resp_id}), 64'd0);

      for (int i = 0; i < 9; i++) begin
         run_op(tbl[i].id, tbl[i].sub, tbl[i].a, tbl[i].b, sum, cout, ovf, rid, lat);
         chk($sformatf("t%0d_sum", i), 64'(sum), 64'(tbl[i].sum));
         chk($sformatf("t%0d_cout", i), 64'(cout), 64'(tbl[i].cout));
         chk($sformatf("t%0d_ovf", i), 64'(ovf), 64'(tbl[i].ovf));
         chk($sformatf("t%0d_id", i), 64'(rid), 64'(tbl[i].id));
         chk($sformatf("t%0d_lat", i), 64'(lat), 64'(LAT));
      end

      // both requesters streaming: arbitration order after reset
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      drive_req(0, 1, 0, 32'd10, 32'd20);
      drive_req(1, 1, 1, 32'd30, 32'd5);
      resp_ready = 1;
      n = 0; k = 0;
      while (k < 4 && n < 200) begin
         @(negedge clk);
         n++;
         if (resp_valid && resp_ready) begin
            ids[k] = resp_id;
            k++;
         end
      end
      chk("arb_count", 64'(k), 64'd4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("arb_id%0d", i), 64'(ids[i]), 64'(RR ? i[0] : 1'b0));
      drain();

      // long stall in DONE with both requesters waiting
      @(posedge clk); #1;
      drive_req(0, 1, 0, 32'h1234_5678, 32'h1111_1111);
      wait_accept(0, "stall_accept");
      @(posedge clk); #1;
      drive_req(1, 1, 0, 32'd1, 32'd1);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!resp_valid && n < 30);
      held = 32'h2345_6789;
      chk("stall_first", 64'(resp_sum), 64'(held));
      repeat (10) begin
         @(negedge clk);
         chk("stall_valid", 64'(resp_valid), 64'd1);
         chk("stall_sum", 64'(resp_sum), 64'(held));
         chk("stall_ready", 64'({req0_ready, req1_ready}), 64'd0);
      end
      @(posedge clk); #1 resp_ready = 1;
      @(negedge clk);
      chk("release_noacc", 64'({req0_ready, req1_ready}), 64'd0);
      @(posedge clk); #1 resp_ready = 0;
      @(negedge clk);
      chk("release_idle", 64'(resp_valid), 64'd0);
      chk("release_held", 64'(resp_sum), 64'(held));
      chk("release_grant", 64'({req1_ready, req0_ready}), RR ? 64'd2 : 64'd1);
      drain();

      // ready stays low while reset is held
      @(posedge clk); #1;
      rst = 1;
      drive_req(0, 1, 0, 32'd3, 32'd4);
      @(negedge clk);
      chk("rst_ready0", 64'(req0_ready), 64'd0);
      @(posedge clk); #1 rst = 0;
      drain();

      // reset during RUN slice 2 aborts the operation
      @(posedge clk); #1;
      drive_req(1, 1, 0, 32'hFFFF_FFFF, 32'd1);
      wait_accept(1, "abort_accept");
      @(posedge clk); #1 req1_valid = 0;
      @(posedge clk); #1;
      @(posedge clk); #1 rst = 1;
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("abort_valid", 64'(resp_valid), 64'd0);
      chk("abort_sum", 64'(resp_sum), 64'd0);
      chk("abort_flags", 64'({resp_cout, resp_ovf, resp_id}), 64'd0);
      chk("abort_ready", 64'({req0_ready, req1_ready}), 64'd0);
      resp_ready = 0;
      repeat (8) begin
         @(negedge clk);
         chk("abort_novalid", 64'(resp_valid), 64'd0);
      end

      // random traffic, checked by the monitor
      repeat (3000) begin
         @(posedge clk); #1;
         rst        = ($urandom_range(0, 99) == 0);
         req0_valid = ($urandom_range(0, 3) != 0);
         req1_valid = ($urandom_range(0, 3) != 0);
         req0_sub   = $urandom_range(0, 1) != 0;
         req1_sub   = $urandom_range(0, 1) != 0;
         req0_a     = rnd_op();
         req0_b     = rnd_op();
         req1_a     = rnd_op();
         req1_b     = rnd_op();
         resp_ready = ($urandom_range(0, 2) != 0);
      end
      @(posedge clk); #1 rst = 0;
      drain();
      @(negedge clk);
      mon_on = 0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
